// File: rtl/div_unit.sv
// Multi-cycle restoring radix-2 divider for DIV/DIVU. It iterates on operand magnitudes and applies sign correction at the end.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor goes straight to FINISH with the same divide-by-zero result.
`timescale 1ns/1ps

module div_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        signed_div,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        cancel,
   output logic        stall,
   output logic        ready,
   output logic [31:0] hi_out,
   output logic [31:0] lo_out
);

   // state  | meaning
   // IDLE   | waiting for start, outputs hold last result
   // DIV    | one restoring step per cycle, counter 0..31
   // FINISH | ready pulse, results valid on hi_out/lo_out
   typedef enum logic [1:0] {S_IDLE, S_DIV, S_FINISH} state_t;

   state_t      r_state;
   logic [5:0]  r_cnt;
   logic [31:0] r_rem;
   logic [31:0] r_quo;
   logic [31:0] r_dvs;
   logic        r_sign_a;
   logic        r_sign_b;
   logic        r_signed;
   logic        r_ready;
   logic [31:0] r_hi;
   logic [31:0] r_lo;

   logic [31:0] w_abs_a;
   logic [31:0] w_abs_b;
   logic [32:0] w_shift;
   logic [32:0] w_diff;
   logic        w_ge;
   logic [31:0] w_q_mag;
   logic [31:0] w_r_mag;
   logic [31:0] w_q_fin;
   logic [31:0] w_r_fin;
   logic        w_fast_zero;
   logic [31:0] w_zero_lo;

   assign w_abs_a = (signed_div && a[31]) ? 32'(-a) : a;
   assign w_abs_b = (signed_div && b[31]) ? 32'(-b) : b;

   // The quotient register doubles as the dividend shifter, so its MSB feeds the partial remainder.
   assign w_shift = {r_rem, r_quo[31]};
   assign w_diff  = w_shift - {1'b0, r_dvs};
   assign w_ge    = ~w_diff[32];
   assign w_q_mag = {r_quo[30:0], w_ge};
   assign w_r_mag = w_ge ? w_diff[31:0] : w_shift[31:0];
   assign w_q_fin = (r_signed && (r_sign_a ^ r_sign_b)) ? 32'(-w_q_mag) : w_q_mag;
   assign w_r_fin = (r_signed && r_sign_a) ? 32'(-w_r_mag) : w_r_mag;

   // These values match what the full iteration produces for a zero divisor.
   assign w_zero_lo = (signed_div && a[31]) ? 32'h0000_0001 : 32'hFFFF_FFFF;
`ifdef DIV_ZERO_FAST_EN
   assign w_fast_zero = (b == 32'h0);
`else
   assign w_fast_zero = 1'b0;
`endif

   assign stall  = ((r_state == S_IDLE) && start && !cancel) || (r_state == S_DIV);
   assign ready  = r_ready;
   assign hi_out = r_hi;
   assign lo_out = r_lo;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_rem    <= '0;
         r_quo    <= '0;
         r_dvs    <= '0;
         r_sign_a <= 1'b0;
         r_sign_b <= 1'b0;
         r_signed <= 1'b0;
         r_ready  <= 1'b0;
         r_hi     <= '0;
         r_lo     <= '0;
      end else begin
         r_ready <= 1'b0;
         if (cancel) begin
            r_state <= S_IDLE;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (start) begin
                     if (w_fast_zero) begin
                        r_lo    <= w_zero_lo;
                        r_hi    <= a;
                        r_ready <= 1'b1;
                        r_state <= S_FINISH;
                     end else begin
                        r_rem    <= '0;
                        r_quo    <= w_abs_a;
                        r_dvs    <= w_abs_b;
                        r_sign_a <= a[31];
                        r_sign_b <= b[31];
                        r_signed <= signed_div;
                        r_cnt    <= '0;
                        r_state  <= S_DIV;
                     end
                  end
               end
               S_DIV: begin
                  r_rem <= w_r_mag;
                  r_quo <= w_q_mag;
                  r_cnt <= r_cnt + 6'd1;
                  if (r_cnt == 6'd31) begin
                     r_lo    <= w_q_fin;
                     r_hi    <= w_r_fin;
                     r_ready <= 1'b1;
                     r_state <= S_FINISH;
                  end
               end
               S_FINISH: r_state <= S_IDLE;
               default:  r_state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_div_unit.sv
// Directed and random checks of div_unit against a behavioural divide model held in a scoreboard.
`timescale 1ns/1ps

module tb_div_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        signed_div;
   logic        cancel;
   logic [31:0] a;
   logic [31:0] b;
   logic        stall;
   logic        ready;
   logic [31:0] hi_out;
   logic [31:0] lo_out;

   int          n_checks = 0;
   int          n_err    = 0;
   logic [63:0] sb_q[$];
   logic [31:0] last_lo  = '0;
   logic [31:0] last_hi  = '0;

`ifdef DIV_ZERO_FAST_EN
   localparam bit FAST = 1'b1;
`else
   localparam bit FAST = 1'b0;
`endif

   div_unit dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .signed_div (signed_div),
      .a          (a),
      .b          (b),
      .cancel     (cancel),
      .stall      (stall),
      .ready      (ready),
      .hi_out     (hi_out),
      .lo_out     (lo_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Returns {lo, hi}.
   function automatic logic [63:0] model(input logic sgn, input logic [31:0] x, input logic [31:0] y);
      logic signed [31:0] sx;
      logic signed [31:0] sy;
      logic [31:0]        q;
      logic [31:0]        r;
      sx = x;
      sy = y;
      if (y == 32'h0) begin
         q = (sgn && x[31]) ? 32'h1 : 32'hFFFF_FFFF;
         r = x;
      end else if (sgn && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
         q = 32'h8000_0000;
         r = 32'h0;
      end else if (sgn) begin
         q = sx / sy;
         r = sx % sy;
      end else begin
         q = x / y;
         r = x % y;
      end
      return {q, r};
   endfunction

   task automatic run_div(input string tag, input logic sgn, input logic [31:0] x, input logic [31:0] y);
      int          lat_exp;
      int          k;
      bit          stall_ok;
      logic [63:0] e;
      lat_exp = (FAST && y == 32'h0) ? 1 : 33;
      @(negedge clk);
      start = 1'b1; signed_div = sgn; a = x; b = y;
      sb_q.push_back(model(sgn, x, y));
      #1;
      chk({tag, " stall_at_N"}, 32'(stall), 32'd1);
      stall_ok = 1'b1;
      k = 0;
      while (k < 40) begin
         @(negedge clk);
         k++;
         if (ready) break;
         if (!stall) stall_ok = 1'b0;
      end
      chk({tag, " latency"}, 32'(k), 32'(lat_exp));
      chk({tag, " stall_during"}, 32'(stall_ok), 32'd1);
      chk({tag, " stall_at_ready"}, 32'(stall), 32'd0);
      e = sb_q.pop_front();
      chk({tag, " lo"}, lo_out, e[63:32]);
      chk({tag, " hi"}, hi_out, e[31:0]);
      last_lo = e[63:32];
      last_hi = e[31:0];
      start = 1'b0;
      @(negedge clk);
      chk({tag, " ready_pulse_end"}, 32'(ready), 32'd0);
      chk({tag, " stall_idle"}, 32'(stall), 32'd0);
   endtask

   initial begin
      bit          no_ready;
      bit          held;
      logic [31:0] rx;
      logic [31:0] ry;
      rst = 1'b1; start = 1'b0; signed_div = 1'b0; cancel = 1'b0; a = '0; b = '0;
      repeat (3) @(negedge clk);
      chk("reset ready", 32'(ready), 32'd0);
      chk("reset hi", hi_out, 32'h0);
      chk("reset lo", lo_out, 32'h0);
      chk("reset stall", 32'(stall), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      run_div("divu_100_7",    1'b0, 32'd100, 32'd7);
      run_div("div_m7_2",      1'b1, 32'hFFFF_FFF9, 32'd2);
      run_div("div_7_m2",      1'b1, 32'd7, 32'hFFFF_FFFE);
      run_div("div_ovf",       1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
      run_div("divu_ovf_ops",  1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
      run_div("div_neg_by0",   1'b1, 32'hFFFF_FFF0, 32'h0);
      run_div("div_pos_by0",   1'b1, 32'd12345, 32'h0);
      run_div("divu_by0",      1'b0, 32'hDEAD_BEEF, 32'h0);

      // Cancel mid-iteration: no ready, outputs keep the previous result.
      @(negedge clk);
      start = 1'b1; signed_div = 1'b0; a = 32'd50; b = 32'd5;
      repeat (10) @(negedge clk);
      cancel = 1'b1;
      @(negedge clk);
      start = 1'b0; cancel = 1'b0;
      #1;
      chk("cancel idle_stall", 32'(stall), 32'd0);
      no_ready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (ready) no_ready = 1'b0;
      end
      chk("cancel no_ready", 32'(no_ready), 32'd1);
      chk("cancel lo_held", lo_out, last_lo);
      chk("cancel hi_held", hi_out, last_hi);
      run_div("divu_9_4", 1'b0, 32'd9, 32'd4);

      // Asynchronous reset between edges while iterating.
      @(negedge clk);
      start = 1'b1; signed_div = 1'b0; a = 32'd1000; b = 32'd3;
      repeat (5) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("midrst ready", 32'(ready), 32'd0);
      chk("midrst hi", hi_out, 32'h0);
      chk("midrst lo", lo_out, 32'h0);
      start = 1'b0;
      #1;
      chk("midrst stall", 32'(stall), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      no_ready = 1'b1;
      held = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (ready) no_ready = 1'b0;
         if (hi_out !== 32'h0 || lo_out !== 32'h0) held = 1'b0;
      end
      chk("midrst no_ready", 32'(no_ready), 32'd1);
      chk("midrst outputs_zero", 32'(held), 32'd1);

      for (int i = 0; i < 6; i++) begin
         rx = $urandom;
         ry = (i % 2 == 0) ? ($urandom >> $urandom_range(0, 28)) : $urandom;
         if (ry == 32'h0) ry = 32'd3;
         run_div($sformatf("rand%0d", i), 1'(i % 3 != 0), rx, ry);
      end

      chk("scoreboard empty", 32'(sb_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
